// File: rtl/noc_inject_port.sv
// NoC injection port: in-order input queue feeding a one-cycle tx register,
// gated by per-VC credit counters for the downstream VC FIFOs.
module noc_inject_credit #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic gnt,
  input  logic take,
  output logic avail,
  output logic ovf
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] MAX = CW'(DEPTH - 1);

  logic [CW-1:0] cnt;

  assign avail = (cnt != '0);
  // A return and a consume in the same cycle cancel, so no overflow then.
  assign ovf   = gnt && !take && (cnt == MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= MAX;
    else begin
      case ({gnt, take})
        2'b10:   if (cnt != MAX) cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module noc_inject_port #(
  parameter int A_W           = 3,
  parameter int D_W           = 8,
  parameter int VC_W          = 4,
  parameter int VC_FIFO_DEPTH = 4,
  parameter int IQ_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [A_W-1:0]           in_dest,
  input  logic [D_W-1:0]           in_data,
  input  logic [$clog2(VC_W)-1:0]  in_vc,
  output logic [VC_W-1:0]          tx_vc_target,
  output logic [A_W+D_W-1:0]       tx_packet,
  input  logic [VC_W-1:0]          tx_vc_credit_gnt,
  output logic                     credit_err,
  output logic [31:0]              sent_count
);
  localparam int VCI_W = $clog2(VC_W);
  localparam int PW    = $clog2(IQ_DEPTH);

  typedef struct packed {
    logic [VCI_W-1:0] vc;
    logic [A_W-1:0]   dest;
    logic [D_W-1:0]   data;
  } iq_entry_t;

  iq_entry_t        mem [IQ_DEPTH];
  iq_entry_t        head;
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             empty, full, ready_en;
  logic             accept, bad_vc, push, issue;
  logic [VC_W-1:0]  issue_oh, avail, ovf;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // ready_en keeps in_ready low while in reset and rises on the first edge after.
  assign in_ready = ready_en && !full;
  assign accept   = in_valid && in_ready;
  assign bad_vc   = ({1'b0, in_vc} >= (VCI_W+1)'(VC_W));
  assign push     = accept && !bad_vc;

  assign head     = mem[rd_ptr[PW-1:0]];
  assign issue    = !empty && avail[head.vc];
  assign issue_oh = issue ? (VC_W'(1) << head.vc) : '0;

  noc_inject_credit #(.DEPTH(VC_FIFO_DEPTH)) u_cred [VC_W-1:0] (
    .clk   (clk),
    .rst   (rst),
    .gnt   (tx_vc_credit_gnt),
    .take  (issue_oh),
    .avail (avail),
    .ovf   (ovf)
  );

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= '{vc: in_vc, dest: in_dest, data: in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ready_en     <= 1'b0;
      tx_vc_target <= '0;
      tx_packet    <= '0;
      credit_err   <= 1'b0;
      sent_count   <= '0;
    end else begin
      ready_en     <= 1'b1;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      tx_vc_target <= issue_oh;
      tx_packet    <= issue ? {head.dest, head.data} : '0;
      if (issue) sent_count <= sent_count + 32'd1;
      if ((|ovf) || (accept && bad_vc)) credit_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_noc_inject_port.sv
// Directed bench for noc_inject_port: latency, credits, HOL blocking, reset.
module tb_noc_inject_port;
  logic        clk, rst, in_valid, in_ready, credit_err;
  logic [2:0]  in_dest;
  logic [7:0]  in_data;
  logic [1:0]  in_vc;
  logic [3:0]  tx_vc_target, tx_vc_credit_gnt;
  logic [10:0] tx_packet;
  logic [31:0] sent_count;
  int nvec = 0, nerr = 0;

  noc_inject_port dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .in_vc(in_vc),
    .tx_vc_target(tx_vc_target), .tx_packet(tx_packet),
    .tx_vc_credit_gnt(tx_vc_credit_gnt), .credit_err(credit_err),
    .sent_count(sent_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // One clock: drive inputs, take the edge, sample 1ns after, drop strobes.
  task automatic cyc(input logic v, input logic [2:0] d, input logic [7:0] dt,
                     input logic [1:0] vc, input logic [3:0] g);
    in_valid = v; in_dest = d; in_data = dt; in_vc = vc; tx_vc_credit_gnt = g;
    @(posedge clk); #1;
    in_valid = 0; tx_vc_credit_gnt = 0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 0; in_valid = 0; in_dest = 0; in_data = 0; in_vc = 0; tx_vc_credit_gnt = 0;
    #2 rst = 1; #1;
    nvec++; if (tx_vc_target !== 4'h0) begin nerr++; $display("FAIL reset_tgt got %h want 0", tx_vc_target); end
    nvec++; if (tx_packet !== 11'h0) begin nerr++; $display("FAIL reset_pkt got %h want 0", tx_packet); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_rdy got %b want 0", in_ready); end
    nvec++; if (credit_err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", credit_err); end
    nvec++; if (sent_count !== 32'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", sent_count); end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_rdy got %b want 1", in_ready); end
  endtask

  task automatic test_single;
    do_reset();
    cyc(1, 3'd2, 8'hA5, 2'd1, 4'h0);
    nvec++; if (tx_vc_target !== 4'h0) begin nerr++; $display("FAIL single_early got %h want 0", tx_vc_target); end
    cyc(0, 0, 0, 0, 0);
    nvec++; if (tx_vc_target !== 4'b0010) begin nerr++; $display("FAIL single_tgt got %b want 0010", tx_vc_target); end
    nvec++; if (tx_packet !== 11'h2A5) begin nerr++; $display("FAIL single_pkt got %h want 2a5", tx_packet); end
    nvec++; if (sent_count !== 32'd1) begin nerr++; $display("FAIL single_cnt got %0d want 1", sent_count); end
    cyc(0, 0, 0, 0, 0);
    nvec++; if (tx_vc_target !== 4'h0) begin nerr++; $display("FAIL single_idle got %h want 0", tx_vc_target); end
  endtask

  task automatic test_credit_exhaust;
    int issued = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL exh_rdy%0d got %b want 1", i, in_ready); end
      cyc(1, 3'd0, 8'(i + 1), 2'd0, 4'h0);
      if (tx_vc_target != 4'h0) issued++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (tx_vc_target != 4'h0) issued++;
    end
    nvec++; if (issued != 3) begin nerr++; $display("FAIL exh_issued got %0d want 3", issued); end
    nvec++; if (sent_count !== 32'd3) begin nerr++; $display("FAIL exh_cnt got %0d want 3", sent_count); end
    cyc(0, 0, 0, 0, 4'b0001);
    nvec++; if (tx_vc_target !== 4'h0) begin nerr++; $display("FAIL exh_gnt_edge got %h want 0", tx_vc_target); end
    cyc(0, 0, 0, 0, 0);
    nvec++; if (tx_vc_target !== 4'b0001) begin nerr++; $display("FAIL exh_4th_tgt got %b want 0001", tx_vc_target); end
    nvec++; if (tx_packet !== 11'h004) begin nerr++; $display("FAIL exh_4th_pkt got %h want 004", tx_packet); end
    nvec++; if (sent_count !== 32'd4) begin nerr++; $display("FAIL exh_4th_cnt got %0d want 4", sent_count); end
    // p5 stays blocked; three more pushes fill the 4-entry queue.
    for (int i = 0; i < 3; i++) cyc(1, 3'd1, 8'(8'h10 + i), 2'd0, 4'h0);
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL exh_full_rdy got %b want 0", in_ready); end
    nvec++; if (sent_count !== 32'd4) begin nerr++; $display("FAIL exh_full_cnt got %0d want 4", sent_count); end
  endtask

  task automatic test_gnt_and_issue;
    do_reset();
    cyc(1, 3'd1, 8'h0A, 2'd1, 4'h0);
    cyc(1, 3'd1, 8'h0B, 2'd1, 4'h0);
    cyc(1, 3'd1, 8'h0C, 2'd1, 4'h0);   // B issues, vc1 credit now 1
    cyc(1, 3'd1, 8'h0D, 2'd1, 4'b0010); // C issues with a return: credit stays 1
    nvec++; if (tx_packet !== 11'h10C) begin nerr++; $display("FAIL same_c_pkt got %h want 10c", tx_packet); end
    cyc(1, 3'd1, 8'h0E, 2'd1, 4'h0);
    nvec++; if (tx_vc_target !== 4'b0010) begin nerr++; $display("FAIL same_d_tgt got %b want 0010", tx_vc_target); end
    nvec++; if (tx_packet !== 11'h10D) begin nerr++; $display("FAIL same_d_pkt got %h want 10d", tx_packet); end
    cyc(0, 0, 0, 0, 0);
    nvec++; if (tx_vc_target !== 4'h0) begin nerr++; $display("FAIL same_e_blocked got %h want 0", tx_vc_target); end
    nvec++; if (sent_count !== 32'd4) begin nerr++; $display("FAIL same_cnt got %0d want 4", sent_count); end
  endtask

  task automatic test_overflow;
    int issued = 0;
    do_reset();
    cyc(0, 0, 0, 0, 4'b1000);
    nvec++; if (credit_err !== 1'b1) begin nerr++; $display("FAIL ovf_err got %b want 1", credit_err); end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 3'd7, 8'(8'h30 + i), 2'd3, 4'h0);
      if (tx_vc_target != 4'h0) issued++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (tx_vc_target != 4'h0) issued++;
    end
    nvec++; if (issued != 3) begin nerr++; $display("FAIL ovf_issued got %0d want 3", issued); end
    nvec++; if (credit_err !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b want 1", credit_err); end
  endtask

  task automatic test_hol;
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 3'd4, 8'(i), 2'd2, 4'h0);
    cyc(1, 3'd5, 8'h20, 2'd2, 4'h0);
    cyc(1, 3'd6, 8'h30, 2'd0, 4'h0);
    cyc(0, 0, 0, 0, 0);
    nvec++; if (tx_vc_target !== 4'h0) begin nerr++; $display("FAIL hol_blk1 got %h want 0", tx_vc_target); end
    cyc(0, 0, 0, 0, 4'b0100);
    nvec++; if (tx_vc_target !== 4'h0) begin nerr++; $display("FAIL hol_blk2 got %h want 0", tx_vc_target); end
    nvec++; if (sent_count !== 32'd3) begin nerr++; $display("FAIL hol_cnt got %0d want 3", sent_count); end
    cyc(0, 0, 0, 0, 0);
    nvec++; if (tx_vc_target !== 4'b0100 || tx_packet !== 11'h520) begin
      nerr++; $display("FAIL hol_p got %b/%h want 0100/520", tx_vc_target, tx_packet); end
    cyc(0, 0, 0, 0, 0);
    nvec++; if (tx_vc_target !== 4'b0001 || tx_packet !== 11'h630) begin
      nerr++; $display("FAIL hol_q got %b/%h want 0001/630", tx_vc_target, tx_packet); end
  endtask

  task automatic test_async_reset;
    int stale = 0;
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 3'd3, 8'(8'h40 + i), 2'd0, 4'h0);
    #2 rst = 1; #1;
    nvec++; if (tx_vc_target !== 4'h0 || tx_packet !== 11'h0) begin
      nerr++; $display("FAIL arst_tx got %h/%h want 0/0", tx_vc_target, tx_packet); end
    nvec++; if (sent_count !== 32'd0 || in_ready !== 1'b0) begin
      nerr++; $display("FAIL arst_state got cnt=%0d rdy=%b want 0/0", sent_count, in_ready); end
    tx_vc_credit_gnt = 4'hF;
    @(posedge clk); #3 rst = 0; tx_vc_credit_gnt = 4'h0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (tx_vc_target != 4'h0) stale++;
    end
    nvec++; if (stale != 0) begin nerr++; $display("FAIL arst_stale got %0d want 0", stale); end
    nvec++; if (credit_err !== 1'b0) begin nerr++; $display("FAIL arst_gnt_ignored got %b want 0", credit_err); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL arst_rdy got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit_exhaust();
    test_gnt_and_issue();
    test_overflow();
    test_hol();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
